yarp_fetch_ctrl: RTL
====================

YARP_FETCH_CTRL -- requirements
Module: yarp_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 imem_req_o  output  1  instruction-memory request valid.
REQ-005 imem_addr_o  output  32  request word address.
REQ-006 imem_gnt_i  input  1  request accepted this cycle.
REQ-007 imem_rvalid_i  input  1  read data valid.
REQ-008 imem_rdata_i  input  32  read data.
REQ-009 branch_taken_i  input  1  qualified branch outcome from branch control.
REQ-010 branch_target_i  input  32  branch target.
REQ-011 jump_i  input  1  JAL/JALR redirect.
REQ-012 jump_target_i  input  32  jump target.
REQ-013 instr_valid_o  output  1  fetched instruction valid.
REQ-014 instr_ready_i  input  1  decode accepts instruction.
REQ-015 instr_o  output  32  fetched instruction.
REQ-016 instr_pc_o  output  32  address of instr_o.

Function
REQ-017 States SHALL be: RST, REQ, WAIT, VALID; registers: pc (next fetch), fetch_addr (in-flight), discard flag.
REQ-018 redirect = jump_i | branch_taken_i; target = jump_target_i if jump_i else branch_target_i; target[1:0] SHALL be forced to 0.
REQ-019 RST -> REQ unconditionally after one cycle with reset low; fetch_addr <= pc on entry to REQ.
REQ-020 REQ: imem_req_o=1, imem_addr_o=fetch_addr; address SHALL be held stable until imem_gnt_i; on gnt -> WAIT.
REQ-021 imem_req_o SHALL be 0 in RST, WAIT, VALID; one request outstanding max.
REQ-022 WAIT, rvalid, discard=0, no redirect: instr_o<=rdata, instr_pc_o<=fetch_addr, instr_valid_o<=1, pc<=fetch_addr+4 (mod 2^32), -> VALID.
REQ-023 WAIT, rvalid, discard=1: data dropped, discard<=0, -> REQ (fetch_addr<=pc).
REQ-024 VALID: instr_valid_o and instr_o/instr_pc_o held until instr_valid_o & instr_ready_i; then instr_valid_o<=0, -> REQ.
REQ-025 Redirect in RST: ignored.
REQ-026 Redirect in REQ (with or without gnt): pc<=target, discard<=1; request completes at held address; on gnt -> WAIT.
REQ-027 Redirect in WAIT: pc<=target; if rvalid same cycle, data dropped and -> REQ; else discard<=1, stay WAIT.
REQ-028 Redirect in VALID: pc<=target, instr_valid_o<=0, -> REQ; redirect wins over simultaneous instr_ready_i (instruction not consumed).
REQ-029 Redirect and discard already set: pc<=latest target; single discard only.
REQ-030 pc increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-031 Fetch latency: address to instr_valid_o = gnt cycle + rvalid cycle + 1 register stage; no combinational path rdata->instr_o.

Reset
REQ-032 reset=1 at posedge SHALL, in any state: state<=RST, pc<=RESET_PC, fetch_addr<=RESET_PC, discard<=0, imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0.
REQ-033 rvalid/gnt during RST SHALL be ignored; memory is reset with the same signal, so no stale response after reset.

Verification
REQ-034 Reset release, gnt same cycle as req, rvalid next cycle, rdata=32'h0000_0013 -> req at 0x0 in cycle 1, instr_valid_o=1, instr_o=0x13, instr_pc_o=0x0 in cycle 3; next req addr 0x4 after ready.
REQ-035 gnt held low 5 cycles with branch_taken_i pulse (target 0x100) in cycle 2 -> imem_addr_o stays 0x0 until gnt; response dropped; next req addr 0x100; no instr_valid_o for 0x0.
REQ-036 VALID with instr_ready_i=0 for 4 cycles -> instr_o/instr_pc_o stable, imem_req_o=0; ready=1 -> valid drops next cycle.
REQ-037 VALID, instr_ready_i=1 and jump_i=1 (target 0x203) same cycle -> valid drops, next req addr 0x200, instruction not consumed.
REQ-038 RESET_PC=32'hFFFF_FFFC, one fetch -> next req addr 0x0; reset asserted in WAIT -> all outputs zero next cycle, refetch from RESET_PC.

Source files
------------

// File: rtl/yarp_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request,
// redirect squashing and a registered valid/ready output stage.
module yarp_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o
);

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_VALID = 2'd3;

    localparam logic [31:0] W_RESET_PC = {RESET_PC[31:2], 2'b00};

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_addr;
    logic        r_discard;
    logic        r_instr_valid;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;

    logic        w_redirect;
    logic [31:0] w_raw_target;
    logic [31:0] w_target;

    assign w_redirect   = jump_i | branch_taken_i;
    assign w_raw_target = jump_i ? jump_target_i : branch_target_i;
    assign w_target     = {w_raw_target[31:2], 2'b00};

    // Address is zeroed outside REQ so an idle bus carries no stale value.
    assign imem_req_o    = (r_state == ST_REQ);
    assign imem_addr_o   = imem_req_o ? r_fetch_addr : 32'd0;
    assign instr_valid_o = r_instr_valid;
    assign instr_o       = r_instr;
    assign instr_pc_o    = r_instr_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RST;
            r_pc          <= W_RESET_PC;
            r_fetch_addr  <= W_RESET_PC;
            r_discard     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= 32'd0;
            r_instr_pc    <= 32'd0;
        end else begin
            unique case (r_state)
                ST_RST: begin
                    r_state      <= ST_REQ;
                    r_fetch_addr <= r_pc;
                end
                ST_REQ: begin
                    // Address stays put; the redirect only marks the
                    // eventual response for dropping.
                    if (w_redirect) begin
                        r_pc      <= w_target;
                        r_discard <= 1'b1;
                    end
                    if (imem_gnt_i) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                    if (imem_rvalid_i) begin
                        if (w_redirect || r_discard) begin
                            r_discard    <= 1'b0;
                            r_state      <= ST_REQ;
                            r_fetch_addr <= w_redirect ? w_target : r_pc;
                        end else begin
                            r_instr       <= imem_rdata_i;
                            r_instr_pc    <= r_fetch_addr;
                            r_instr_valid <= 1'b1;
                            r_pc          <= r_fetch_addr + 32'd4;
                            r_state       <= ST_VALID;
                        end
                    end else if (w_redirect) begin
                        r_discard <= 1'b1;
                    end
                end
                ST_VALID: begin
                    // Redirect beats ready: the held instruction is squashed.
                    if (w_redirect) begin
                        r_pc          <= w_target;
                        r_fetch_addr  <= w_target;
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_REQ;
                    end else if (instr_ready_i) begin
                        r_fetch_addr  <= r_pc;
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_RST;
                end
            endcase
        end
    end

endmodule
